battleship_game_ctrl: RTL and testbench
=======================================

// Module: battleship_game_ctrl
// PURPOSE
//  Parametrised Battleship game core: NxN boards, 1..MAX_SHIPS single-cell ships, cursor, placement check,
//  LFSR PC placement/shots, turn FSM, win/lose detection. Sits between debounced buttons (clk_ms domain)
//  and the VGA/7-seg renderers, which read the flattened boards and counters.
// PARAMETERS
//  BOARD_N      5        board side; boards are BOARD_N x BOARD_N, CELLS = BOARD_N*BOARD_N
//  MAX_SHIPS    5        upper clamp on requested ship count
//  PC_DELAY     8        cycles PC waits in PC_TURN before shooting (>=1)
//  LFSR_SEED    16'hACE1 reset value of 16-bit LFSR (must be nonzero)
//  CURSOR_WRAP  0        0: cursor saturates at edges; 1: wraps modulo BOARD_N
// PORTS
//  clk              in   1            game clock (clk_ms)
//  rst              in   1            synchronous reset, active-low
//  move_up/down/left/right in 1 each  one-cycle cursor pulses
//  ships_req        in   CW           requested ship count, CW=$clog2(MAX_SHIPS+1)
//  confirm_amount   in   1            pulse: latch ships_req
//  confirm_place    in   1            pulse: place ship at cursor
//  fire             in   1            pulse: shoot PC board at cursor
//  cur_i, cur_j     out  IW each      cursor row/col, IW=$clog2(BOARD_N)
//  state            out  game_state_t current FSM state
//  player_board     out  2*CELLS      flat, cell k=(i*BOARD_N+j) at [2k+1:2k]
//  pc_board         out  2*CELLS      same; renderer masks SHIP cells
//  ships_total      out  CW           clamped count; player_left, pc_left out CW each
//  placement_error  out  1            1-cycle pulse: placement on occupied cell
//  shot_error       out  1            1-cycle pulse: fire on already-shot cell
// BEHAVIOUR
//  Reset (rst==0 at edge): state=DECIDE, boards all EMPTY, cursor (0,0), counters 0, errors 0, LFSR=seed.
//  Cell codes: EMPTY=00 SHIP=01 MISS=10 HIT=11. LFSR free-runs every cycle, all states.
//  DECIDE: confirm_amount -> ships_total=clamp(ships_req,1,MAX_SHIPS) (0->1); player_left=pc_left=total; ->PLACE.
//  PLACE: cursor moves; confirm_place: EMPTY cell -> SHIP, placed++; else placement_error, no change.
//   Same-cycle placed reaching total -> PC_SETUP next cycle.
//  PC_SETUP: each cycle cand=lfsr%CELLS; if pc_board[cand]==EMPTY place SHIP, pc_placed++; else skip.
//   pc_placed==total -> PLAYER_TURN, cursor reset to (0,0). No input effect in this state.
//  PLAYER_TURN: fire on pc cell: SHIP->HIT, pc_left--; EMPTY->MISS; HIT/MISS->shot_error, stay.
//   After valid shot: pc_left==0 (post-update) -> VICTORY else -> PC_TURN. Board write visible next cycle.
//  PC_TURN: count PC_DELAY cycles, then probe: first cand=lfsr%CELLS, then cand+1 mod CELLS per cycle
//   until unshot cell (EMPTY/SHIP) found (<=CELLS probes). Shoot: SHIP->HIT, player_left--; EMPTY->MISS.
//   player_left==0 -> DEFEAT else -> PLAYER_TURN. Buttons ignored.
//  VICTORY/DEFEAT: terminal; only rst exits. Boards/counters held.
//  Cursor: active in PLACE and PLAYER_TURN only. Priority up>down>left>right, one step per cycle.
//   up=i-1, down=i+1, left=j-1, right=j+1. Edge: saturate, or wrap if CURSOR_WRAP.
//  Simultaneous move+confirm/fire: action uses pre-move cursor; move applied same edge.
//  Inputs outside their state ignored; confirm_amount after DECIDE has no effect.
//  Reset mid-game: full restart, no residue in either board.
// STRUCTURE
//  battleship_pkg: game_state_t {DECIDE,PLACE,PC_SETUP,PLAYER_TURN,PC_TURN,VICTORY,DEFEAT},
//   cell_t {EMPTY,SHIP,MISS,HIT}.
//  Sub-module bs_lfsr16 (x^16+x^14+x^13+x^11, SEED param, active-low sync rst). Rest in one file.
// TESTING
//  1 ships_req=0, confirm_amount -> ships_total=1, state=PLACE; ships_req=7 (MAX 5) -> total=5.
//  2 PLACE at (0,0) twice -> 2nd cycle placement_error=1 for 1 cycle, placed stays 1.
//  3 move_up at (0,0) -> (0,0); CURSOR_WRAP=1 -> (4,0); up+left same cycle -> only up applied.
//  4 total=2, place (0,0),(1,1) -> PC_SETUP ends with exactly 2 SHIP cells in pc_board, PLAYER_TURN.
//  5 fire on known pc SHIP -> HIT, pc_left 2->1, PC_TURN; refire same cell later -> shot_error, no turn change.
//  6 scripted game: sink both PC ships -> VICTORY; force PC hits both -> DEFEAT; rst=0 mid-PC_TURN -> DECIDE,
//    boards clear; PC never shoots a cell twice (scoreboard over 200 turns, BOARD_N=7).

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared types for the Battleship game core.
//   game_state_t : turn/phase FSM states
//   cell_t       : 2-bit board cell code (bit1 = already shot, bit0 = ship present)
//   shoot()      : result of firing on a cell (SHIP->HIT, EMPTY->MISS)
package battleship_pkg;

  typedef enum logic [2:0] {
    DECIDE,
    PLACE,
    PC_SETUP,
    PLAYER_TURN,
    PC_TURN,
    VICTORY,
    DEFEAT
  } game_state_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    SHIP  = 2'b01,
    MISS  = 2'b10,
    HIT   = 2'b11
  } cell_t;

  // The encoding makes a shot simply set bit1 while keeping the ship bit.
  function automatic cell_t shoot(input cell_t c);
    logic [1:0] v;
    v = c;
    return cell_t'({1'b1, v[0]});
  endfunction

endpackage

// File: rtl/bs_lfsr16.sv
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11, advancing every cycle.
// Ports:
//   clk    : clock
//   rst    : synchronous reset, active-low (loads SEED)
//   lfsr_o : current LFSR state
module bs_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic        fb_d;

  assign fb_d = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk) begin
    if (!rst) lfsr_q <= SEED;
    else      lfsr_q <= {lfsr_q[14:0], fb_d};
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/battleship_game_ctrl.sv
// Battleship game core: cursor, player placement, random PC placement, turn FSM,
// PC shooting with linear probing, win/lose detection.
// Ports:
//   clk, rst                       : clock, synchronous active-low reset
//   move_up/down/left/right        : one-cycle cursor pulses (priority up>down>left>right)
//   ships_req, confirm_amount      : requested ship count and its latch pulse
//   confirm_place, fire            : place ship / shoot PC board at cursor
//   cur_i, cur_j, state            : cursor row/col and FSM state
//   player_board, pc_board         : flat boards, cell k=i*BOARD_N+j at [2k+1:2k]
//   ships_total, player_left, pc_left : counters
//   placement_error, shot_error    : one-cycle error pulses
module battleship_game_ctrl
  import battleship_pkg::*;
#(
  parameter int          BOARD_N     = 5,
  parameter int          MAX_SHIPS   = 5,
  parameter int          PC_DELAY    = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter bit          CURSOR_WRAP = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 move_up,
  input  logic                                 move_down,
  input  logic                                 move_left,
  input  logic                                 move_right,
  input  logic [$clog2(MAX_SHIPS+1)-1:0]       ships_req,
  input  logic                                 confirm_amount,
  input  logic                                 confirm_place,
  input  logic                                 fire,
  output logic [$clog2(BOARD_N)-1:0]           cur_i,
  output logic [$clog2(BOARD_N)-1:0]           cur_j,
  output game_state_t                          state,
  output logic [2*BOARD_N*BOARD_N-1:0]         player_board,
  output logic [2*BOARD_N*BOARD_N-1:0]         pc_board,
  output logic [$clog2(MAX_SHIPS+1)-1:0]       ships_total,
  output logic [$clog2(MAX_SHIPS+1)-1:0]       player_left,
  output logic [$clog2(MAX_SHIPS+1)-1:0]       pc_left,
  output logic                                 placement_error,
  output logic                                 shot_error
);

  localparam int CELLS = BOARD_N * BOARD_N;
  localparam int CW    = $clog2(MAX_SHIPS + 1);
  localparam int IW    = $clog2(BOARD_N);
  localparam int KW    = $clog2(CELLS);
  localparam int DW    = $clog2(PC_DELAY + 1);
  localparam logic [IW-1:0] EDGE   = IW'(BOARD_N - 1);
  localparam logic [KW-1:0] LAST_K = KW'(CELLS - 1);

  game_state_t          state_q;
  logic [IW-1:0]        cur_i_q, cur_j_q, cur_i_d, cur_j_d;
  logic [CW-1:0]        total_q, player_left_q, pc_left_q, placed_q, pc_placed_q;
  logic [2*CELLS-1:0]   player_q, pc_q;
  logic                 perr_q, serr_q;
  logic [DW-1:0]        delay_q;
  logic [KW-1:0]        probe_q;
  logic                 probing_q;

  logic [15:0]          lfsr;
  logic [KW-1:0]        rand_k, cur_k, probe_k, next_probe_k;
  logic [CW-1:0]        req_clamped;
  cell_t                cur_pl_c, cur_pc_c, setup_c, probe_c;

  bs_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr)
  );

  assign rand_k       = KW'(lfsr % 16'(CELLS));
  assign cur_k        = KW'(cur_i_q) * KW'(BOARD_N) + KW'(cur_j_q);
  // First probe of a PC shot is random; later probes walk forward from there.
  assign probe_k      = probing_q ? probe_q : rand_k;
  assign next_probe_k = (probe_k == LAST_K) ? '0 : probe_k + KW'(1);

  assign cur_pl_c = cell_t'(player_q[{cur_k, 1'b0} +: 2]);
  assign cur_pc_c = cell_t'(pc_q[{cur_k, 1'b0} +: 2]);
  assign setup_c  = cell_t'(pc_q[{rand_k, 1'b0} +: 2]);
  assign probe_c  = cell_t'(player_q[{probe_k, 1'b0} +: 2]);

  assign req_clamped = (ships_req == '0)              ? CW'(1) :
                       (ships_req > CW'(MAX_SHIPS))   ? CW'(MAX_SHIPS) : ships_req;

  // Single-step cursor move; only the highest-priority pulse is honoured.
  always_comb begin
    cur_i_d = cur_i_q;
    cur_j_d = cur_j_q;
    if (move_up) begin
      if (cur_i_q == '0) cur_i_d = CURSOR_WRAP ? EDGE : '0;
      else               cur_i_d = cur_i_q - IW'(1);
    end else if (move_down) begin
      if (cur_i_q == EDGE) cur_i_d = CURSOR_WRAP ? '0 : EDGE;
      else                 cur_i_d = cur_i_q + IW'(1);
    end else if (move_left) begin
      if (cur_j_q == '0) cur_j_d = CURSOR_WRAP ? EDGE : '0;
      else               cur_j_d = cur_j_q - IW'(1);
    end else if (move_right) begin
      if (cur_j_q == EDGE) cur_j_d = CURSOR_WRAP ? '0 : EDGE;
      else                 cur_j_d = cur_j_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= DECIDE;
      cur_i_q       <= '0;
      cur_j_q       <= '0;
      total_q       <= '0;
      player_left_q <= '0;
      pc_left_q     <= '0;
      placed_q      <= '0;
      pc_placed_q   <= '0;
      player_q      <= '0;
      pc_q          <= '0;
      perr_q        <= 1'b0;
      serr_q        <= 1'b0;
      delay_q       <= '0;
      probe_q       <= '0;
      probing_q     <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      serr_q <= 1'b0;
      // Actions below read the pre-move cursor; the move lands on the same edge.
      if (state_q == PLACE || state_q == PLAYER_TURN) begin
        cur_i_q <= cur_i_d;
        cur_j_q <= cur_j_d;
      end
      case (state_q)
        DECIDE: begin
          if (confirm_amount) begin
            total_q       <= req_clamped;
            player_left_q <= req_clamped;
            pc_left_q     <= req_clamped;
            placed_q      <= '0;
            state_q       <= PLACE;
          end
        end
        PLACE: begin
          if (confirm_place) begin
            if (cur_pl_c == EMPTY) begin
              player_q[{cur_k, 1'b0} +: 2] <= SHIP;
              placed_q <= placed_q + CW'(1);
              if (placed_q + CW'(1) == total_q) begin
                pc_placed_q <= '0;
                state_q     <= PC_SETUP;
              end
            end else begin
              perr_q <= 1'b1;
            end
          end
        end
        PC_SETUP: begin
          if (setup_c == EMPTY) begin
            pc_q[{rand_k, 1'b0} +: 2] <= SHIP;
            pc_placed_q <= pc_placed_q + CW'(1);
            if (pc_placed_q + CW'(1) == total_q) begin
              cur_i_q <= '0;
              cur_j_q <= '0;
              state_q <= PLAYER_TURN;
            end
          end
        end
        PLAYER_TURN: begin
          if (fire) begin
            if (cur_pc_c == MISS || cur_pc_c == HIT) begin
              serr_q <= 1'b1;
            end else begin
              pc_q[{cur_k, 1'b0} +: 2] <= shoot(cur_pc_c);
              if (cur_pc_c == SHIP) pc_left_q <= pc_left_q - CW'(1);
              if (cur_pc_c == SHIP && pc_left_q == CW'(1)) begin
                state_q <= VICTORY;
              end else begin
                delay_q   <= '0;
                probing_q <= 1'b0;
                state_q   <= PC_TURN;
              end
            end
          end
        end
        PC_TURN: begin
          if (delay_q != DW'(PC_DELAY)) begin
            delay_q <= delay_q + DW'(1);
          end else if (probe_c == MISS || probe_c == HIT) begin
            probe_q   <= next_probe_k;
            probing_q <= 1'b1;
          end else begin
            player_q[{probe_k, 1'b0} +: 2] <= shoot(probe_c);
            probing_q <= 1'b0;
            if (probe_c == SHIP) player_left_q <= player_left_q - CW'(1);
            if (probe_c == SHIP && player_left_q == CW'(1)) state_q <= DEFEAT;
            else                                            state_q <= PLAYER_TURN;
          end
        end
        default: ; // VICTORY / DEFEAT hold until reset
      endcase
    end
  end

  assign cur_i           = cur_i_q;
  assign cur_j           = cur_j_q;
  assign state           = state_q;
  assign player_board    = player_q;
  assign pc_board        = pc_q;
  assign ships_total     = total_q;
  assign player_left     = player_left_q;
  assign pc_left         = pc_left_q;
  assign placement_error = perr_q;
  assign shot_error      = serr_q;

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Directed bench for battleship_game_ctrl.
//   dut   : 5x5, saturating cursor, main directed checks
//   dut_w : 5x5, wrapping cursor, shares dut's inputs (cursor checks only)
//   dut_b : 7x7, wrapping cursor, repeated scripted games with a PC-shot scoreboard
module tb_battleship_game_ctrl;
  import battleship_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---- 5x5 instances (shared stimulus) ----
  logic rst_n, mu, md, ml, mr, ca, cp, fi;
  logic [2:0] req_a;
  logic [2:0] ci_a, cj_a, ci_w, cj_w;
  game_state_t st_a, st_w;
  logic [49:0] pb_a, pcb_a, pb_w, pcb_w;
  logic [2:0] tot_a, pl_a, pcl_a, tot_w, pl_w, pcl_w;
  logic perr_a, serr_a, perr_w, serr_w;

  battleship_game_ctrl #(.BOARD_N(5), .MAX_SHIPS(5), .PC_DELAY(3), .LFSR_SEED(16'hACE1), .CURSOR_WRAP(1'b0)) dut (
    .clk(clk), .rst(rst_n), .move_up(mu), .move_down(md), .move_left(ml), .move_right(mr),
    .ships_req(req_a), .confirm_amount(ca), .confirm_place(cp), .fire(fi),
    .cur_i(ci_a), .cur_j(cj_a), .state(st_a), .player_board(pb_a), .pc_board(pcb_a),
    .ships_total(tot_a), .player_left(pl_a), .pc_left(pcl_a),
    .placement_error(perr_a), .shot_error(serr_a));

  battleship_game_ctrl #(.BOARD_N(5), .MAX_SHIPS(5), .PC_DELAY(3), .LFSR_SEED(16'hACE1), .CURSOR_WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst_n), .move_up(mu), .move_down(md), .move_left(ml), .move_right(mr),
    .ships_req(req_a), .confirm_amount(ca), .confirm_place(cp), .fire(fi),
    .cur_i(ci_w), .cur_j(cj_w), .state(st_w), .player_board(pb_w), .pc_board(pcb_w),
    .ships_total(tot_w), .player_left(pl_w), .pc_left(pcl_w),
    .placement_error(perr_w), .shot_error(serr_w));

  // ---- 7x7 instance ----
  logic rst_b, mu_b, md_b, ml_b, mr_b, ca_b, cp_b, fi_b;
  logic [2:0] req_b;
  logic [2:0] ci_b, cj_b;
  game_state_t st_b;
  logic [97:0] pb_b, pcb_b;
  logic [2:0] tot_b, pl_b, pcl_b;
  logic perr_b, serr_b;

  battleship_game_ctrl #(.BOARD_N(7), .MAX_SHIPS(5), .PC_DELAY(2), .LFSR_SEED(16'hACE1), .CURSOR_WRAP(1'b1)) dut_b (
    .clk(clk), .rst(rst_b), .move_up(mu_b), .move_down(md_b), .move_left(ml_b), .move_right(mr_b),
    .ships_req(req_b), .confirm_amount(ca_b), .confirm_place(cp_b), .fire(fi_b),
    .cur_i(ci_b), .cur_j(cj_b), .state(st_b), .player_board(pb_b), .pc_board(pcb_b),
    .ships_total(tot_b), .player_left(pl_b), .pc_left(pcl_b),
    .placement_error(perr_b), .shot_error(serr_b));

  int ai, aj, bi, bj;
  logic [49:0] mc_a;
  logic [97:0] mp_b, mc_b;
  int pc_shots_b = 0, defeats_b = 0, victories_b = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int count_code(input logic [127:0] b, input int cells, input logic [1:0] code);
    int n = 0;
    for (int k = 0; k < cells; k++) if (b[2*k +: 2] == code) n++;
    return n;
  endfunction

  function automatic int find_code(input logic [127:0] b, input int cells, input logic [1:0] code, input int nth);
    int seen = 0;
    for (int k = 0; k < cells; k++) begin
      if (b[2*k +: 2] == code) begin
        if (seen == nth) return k;
        seen++;
      end
    end
    return 0;
  endfunction

  task automatic move_a(input int ti, input int tj);
    while (ai > ti) begin mu = 1; tick(); mu = 0; ai--; end
    while (ai < ti) begin md = 1; tick(); md = 0; ai++; end
    while (aj > tj) begin ml = 1; tick(); ml = 0; aj--; end
    while (aj < tj) begin mr = 1; tick(); mr = 0; aj++; end
  endtask

  task automatic move_b(input int ti, input int tj);
    while (bi > ti) begin mu_b = 1; tick(); mu_b = 0; bi--; end
    while (bi < ti) begin md_b = 1; tick(); md_b = 0; bi++; end
    while (bj > tj) begin ml_b = 1; tick(); ml_b = 0; bj--; end
    while (bj < tj) begin mr_b = 1; tick(); mr_b = 0; bj++; end
  endtask

  task automatic wait_a(input game_state_t s, input int limit, input string tag);
    int n = 0;
    while (st_a != s && n < limit) begin tick(); n++; end
    check_val(tag, st_a, s);
  endtask

  task automatic reset_a();
    rst_n = 0; tick(); rst_n = 1; ai = 0; aj = 0;
  endtask

  // One 7x7 game with two player ships; player prefers misses so the PC gets many turns.
  task automatic play_b(input int g);
    int s0, s1, tgt, nchg, ck, pcl, pll, guard, n;
    logic [1:0] oldc, newc;
    s0 = (g * 13) % 49;
    s1 = (g * 13 + 24) % 49;
    rst_b = 0; tick(); rst_b = 1; bi = 0; bj = 0;
    req_b = 3'd2; ca_b = 1; tick(); ca_b = 0;
    move_b(s0 / 7, s0 % 7); cp_b = 1; tick(); cp_b = 0;
    move_b(s1 / 7, s1 % 7); cp_b = 1; tick(); cp_b = 0;
    n = 0;
    while (st_b != PLAYER_TURN && n < 500) begin tick(); n++; end
    check_val("b_setup_done", st_b, PLAYER_TURN);
    mp_b = '0;
    mp_b[2*s0 +: 2] = SHIP;
    mp_b[2*s1 +: 2] = SHIP;
    check_val("b_player_layout", pb_b, mp_b);
    mc_b = pcb_b;  // PC layout is random: captured once, then tracked by the bench
    check_val("b_pc_ship_count", count_code(mc_b, 49, SHIP), 2);
    bi = 0; bj = 0;
    pcl = 2; pll = 2; guard = 0;
    while (st_b == PLAYER_TURN && guard < 120) begin
      guard++;
      tgt = -1;
      for (int k = 0; k < 49; k++) if (tgt < 0 && mc_b[2*k +: 2] == EMPTY) tgt = k;
      for (int k = 0; k < 49; k++) if (tgt < 0 && mc_b[2*k +: 2] == SHIP) tgt = k;
      if (tgt < 0) break;
      move_b(tgt / 7, tgt % 7);
      fi_b = 1; tick(); fi_b = 0;
      if (mc_b[2*tgt +: 2] == SHIP) begin mc_b[2*tgt +: 2] = HIT; pcl--; end
      else mc_b[2*tgt +: 2] = MISS;
      check_val("b_pc_board", pcb_b, mc_b);
      check_val("b_pc_left", pcl_b, pcl);
      if (pcl == 0) begin
        check_val("b_victory", st_b, VICTORY);
        victories_b++;
      end else begin
        check_val("b_to_pc_turn", st_b, PC_TURN);
        n = 0;
        while (st_b == PC_TURN && n < 100) begin tick(); n++; end
        nchg = 0; ck = 0;
        for (int k = 0; k < 49; k++) if (pb_b[2*k +: 2] !== mp_b[2*k +: 2]) begin nchg++; ck = k; end
        check_val("pc_one_new_shot", nchg, 1);
        oldc = mp_b[2*ck +: 2];
        check_val("pc_cell_unshot_before", oldc[1], 1'b0);
        newc = {1'b1, oldc[0]};
        check_val("pc_shot_code", pb_b[2*ck +: 2], newc);
        mp_b[2*ck +: 2] = newc;
        if (oldc == SHIP) pll--;
        pc_shots_b++;
        check_val("b_player_left", pl_b, pll);
        if (pll == 0) begin
          check_val("b_defeat", st_b, DEFEAT);
          defeats_b++;
        end else begin
          check_val("b_back_to_player", st_b, PLAYER_TURN);
        end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1, s2, e;
    rst_n = 0; mu = 0; md = 0; ml = 0; mr = 0; ca = 0; cp = 0; fi = 0; req_a = 3'd0;
    rst_b = 0; mu_b = 0; md_b = 0; ml_b = 0; mr_b = 0; ca_b = 0; cp_b = 0; fi_b = 0; req_b = 3'd0;
    ai = 0; aj = 0; bi = 0; bj = 0;
    tick(); tick();

    // Reset state
    check_val("rst_state", st_a, DECIDE);
    check_val("rst_boards", {pb_a, pcb_a}, 100'd0);
    check_val("rst_cursor", {ci_a, cj_a}, 6'd0);
    check_val("rst_counters", {tot_a, pl_a, pcl_a}, 9'd0);
    check_val("rst_errors", {perr_a, serr_a}, 2'd0);
    rst_n = 1;

    // Ship-count clamping
    req_a = 3'd0; ca = 1; tick(); ca = 0;
    check_val("clamp_zero_total", tot_a, 3'd1);
    check_val("clamp_zero_state", st_a, PLACE);
    reset_a();
    req_a = 3'd7; ca = 1; tick(); ca = 0;
    check_val("clamp_max_total", tot_a, 3'd5);
    check_val("clamp_max_left", {pl_a, pcl_a}, {3'd5, 3'd5});
    reset_a();
    req_a = 3'd2; ca = 1; tick(); ca = 0;
    check_val("total_two", {tot_a, pcl_a}, {3'd2, 3'd2});
    req_a = 3'd4; ca = 1; tick(); ca = 0;
    check_val("amount_ignored_in_place", tot_a, 3'd2);

    // Cursor edges, wrap and priority
    mu = 1; tick(); mu = 0;
    check_val("cur_up_saturate", {ci_a, cj_a}, {3'd0, 3'd0});
    check_val("cur_up_wrap", {ci_w, cj_w}, {3'd4, 3'd0});
    mu = 1; ml = 1; tick(); mu = 0; ml = 0;
    check_val("cur_up_left_wrap", {ci_w, cj_w}, {3'd3, 3'd0});
    mr = 1; tick(); mr = 0;
    md = 1; mr = 1; tick(); md = 0; mr = 0;
    check_val("cur_down_right", {ci_a, cj_a}, {3'd1, 3'd1});
    check_val("cur_down_right_w", {ci_w, cj_w}, {3'd4, 3'd1});
    md = 1; tick(); md = 0;
    check_val("cur_down_wrap", {ci_w, cj_w}, {3'd0, 3'd1});
    for (int k = 0; k < 5; k++) begin mr = 1; tick(); mr = 0; end
    check_val("cur_right_saturate", {ci_a, cj_a}, {3'd2, 3'd4});
    ai = 2; aj = 4;
    move_a(0, 0);
    check_val("cur_home", {ci_a, cj_a}, {3'd0, 3'd0});

    // Placement and placement errors
    cp = 1; tick(); cp = 0;
    check_val("place_first", {perr_a, pb_a}, {1'b0, 50'h1});
    cp = 1; tick(); cp = 0;
    check_val("place_dup_err", perr_a, 1'b1);
    check_val("place_dup_board", pb_a, 50'h1);
    check_val("place_dup_state", st_a, PLACE);
    tick();
    check_val("place_err_pulse_end", perr_a, 1'b0);
    md = 1; cp = 1; tick(); md = 0; cp = 0; ai = 1;
    check_val("place_premove_err", perr_a, 1'b1);
    check_val("place_premove_cursor", {ci_a, cj_a}, {3'd1, 3'd0});
    mr = 1; tick(); mr = 0; aj = 1;
    cp = 1; tick(); cp = 0;
    check_val("place_second_board", pb_a, 50'h1001);
    check_val("place_done_state", st_a, PC_SETUP);

    // PC setup
    wait_a(PLAYER_TURN, 300, "pc_setup_done");
    check_val("pc_setup_ships", count_code(pcb_a, 25, SHIP), 2);
    check_val("pc_setup_empty", count_code(pcb_a, 25, EMPTY), 23);
    check_val("pc_setup_cursor", {ci_a, cj_a}, {3'd0, 3'd0});
    ai = 0; aj = 0;
    mc_a = pcb_a;
    s1 = find_code(mc_a, 25, SHIP, 0);
    s2 = find_code(mc_a, 25, SHIP, 1);

    // Player hits, PC answers, refire error, victory
    move_a(s1 / 5, s1 % 5);
    fi = 1; tick(); fi = 0;
    mc_a[2*s1 +: 2] = HIT;
    check_val("fire_hit_board", pcb_a, mc_a);
    check_val("fire_hit_pc_left", pcl_a, 3'd1);
    check_val("fire_hit_state", st_a, PC_TURN);
    wait_a(PLAYER_TURN, 100, "pc_turn_returns");
    check_val("pc_one_shot_a", count_code(pb_a, 25, MISS) + count_code(pb_a, 25, HIT), 1);
    fi = 1; tick(); fi = 0;
    check_val("refire_err", serr_a, 1'b1);
    check_val("refire_state", st_a, PLAYER_TURN);
    check_val("refire_board", {pcb_a, pcl_a}, {mc_a, 3'd1});
    tick();
    check_val("refire_err_pulse_end", serr_a, 1'b0);
    move_a(s2 / 5, s2 % 5);
    fi = 1; tick(); fi = 0;
    mc_a[2*s2 +: 2] = HIT;
    check_val("victory_board", pcb_a, mc_a);
    check_val("victory_state", st_a, VICTORY);
    check_val("victory_pc_left", pcl_a, 3'd0);
    fi = 1; mu = 1; ca = 1; tick(); tick(); fi = 0; mu = 0; ca = 0;
    check_val("victory_hold_state", st_a, VICTORY);
    check_val("victory_hold_board", pcb_a, mc_a);
    check_val("victory_hold_cursor", {ci_a, cj_a}, {3'(ai), 3'(aj)});

    // Reset in the middle of a PC turn
    reset_a();
    req_a = 3'd1; ca = 1; tick(); ca = 0;
    cp = 1; tick(); cp = 0;
    wait_a(PLAYER_TURN, 300, "pc_setup_done_2");
    ai = 0; aj = 0;
    mc_a = pcb_a;
    e = find_code(mc_a, 25, EMPTY, 0);
    move_a(e / 5, e % 5);
    fi = 1; tick(); fi = 0;
    mc_a[2*e +: 2] = MISS;
    check_val("fire_miss_board", pcb_a, mc_a);
    check_val("fire_miss_state", st_a, PC_TURN);
    rst_n = 0; tick(); rst_n = 1;
    check_val("midgame_rst_state", st_a, DECIDE);
    check_val("midgame_rst_boards", {pb_a, pcb_a}, 100'd0);
    check_val("midgame_rst_counters", {tot_a, pl_a, pcl_a, ci_a, cj_a}, 15'd0);

    // 7x7 scripted games with PC-shot scoreboard
    for (int g = 0; g < 40 && pc_shots_b < 200; g++) play_b(g);
    check_val("b_pc_shots_200", pc_shots_b >= 200, 1'b1);
    check_val("b_defeat_seen", defeats_b > 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
